// File: rtl/control_types_pkg.sv
// Shared control types for the MEM stage: memory operation codes, the
// load/store unit state encoding and byte-lane helper functions.
package control_types_pkg;

    typedef enum logic [3:0] {
        MEM_NOP = 4'd0,
        MEM_LB,
        MEM_LBU,
        MEM_LH,
        MEM_LHU,
        MEM_LW,
        MEM_SB,
        MEM_SH,
        MEM_SW
    } mem_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        DONE  = 2'd3
    } lsu_state_t;

    // Number of bytes moved by an operation (0 for MEM_NOP).
    function automatic logic [2:0] op_size(input mem_op_t op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: return 3'd1;
            MEM_LH, MEM_LHU, MEM_SH: return 3'd2;
            MEM_LW, MEM_SW:          return 3'd4;
            default:                 return 3'd0;
        endcase
    endfunction

    function automatic logic is_store(input mem_op_t op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic logic is_load(input mem_op_t op);
        return (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_LH) ||
               (op == MEM_LHU) || (op == MEM_LW);
    endfunction

    // True when the access crosses into the next word (off + size > 4).
    function automatic logic spans_words(input mem_op_t op, input logic [1:0] off);
        return ({2'b00, off} + {1'b0, op_size(op)}) > 4'd4;
    endfunction

    // Byte enables over two consecutive words: low nibble = first beat.
    function automatic logic [7:0] lane_mask(input mem_op_t op, input logic [1:0] off);
        logic [7:0] m;
        case (op_size(op))
            3'd1:    m = 8'h01;
            3'd2:    m = 8'h03;
            3'd4:    m = 8'h0F;
            default: m = 8'h00;
        endcase
        return m << off;
    endfunction

    // Store data placed on its byte lanes over two words; loads carry no data.
    function automatic logic [63:0] lane_data(input mem_op_t op, input logic [1:0] off,
                                              input logic [31:0] data);
        logic [63:0] d;
        case (op)
            MEM_SB:  d = {56'b0, data[7:0]};
            MEM_SH:  d = {48'b0, data[15:0]};
            MEM_SW:  d = {32'b0, data};
            default: d = 64'b0;
        endcase
        return d << {off, 3'b000};
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed bytes from the two-word read buffer and applies
// sign or zero extension according to the load operation.
module lsu_load_align
    import control_types_pkg::*;
(
    input  logic [55:0] rbuf,
    input  logic [1:0]  off,
    input  mem_op_t     op,
    output logic [31:0] rdata
);

    logic [31:0] window;

    // Shift the buffer so the first addressed byte lands in bits [7:0].
    always_comb begin
        case (off)
            2'd0:    window = rbuf[31:0];
            2'd1:    window = rbuf[39:8];
            2'd2:    window = rbuf[47:16];
            default: window = rbuf[55:24];
        endcase
    end

    // Trim to the access size and extend; non-loads yield zero.
    always_comb begin
        case (op)
            MEM_LB:  rdata = {{24{window[7]}}, window[7:0]};
            MEM_LBU: rdata = {24'b0, window[7:0]};
            MEM_LH:  rdata = {{16{window[15]}}, window[15:0]};
            MEM_LHU: rdata = {16'b0, window[15:0]};
            MEM_LW:  rdata = window;
            default: rdata = 32'b0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: turns one pipeline access into one or two
// word-aligned bus beats (req/ready), stalls the pipeline meanwhile and
// returns the extended load result in a single DONE cycle.
//
// Bus handshake: a beat is offered while mem_req is high; mem_addr, mem_be,
// mem_wdata and mem_we stay constant until the cycle mem_ready is sampled
// high, which completes the beat and (for reads) delivers mem_rdata.
module load_store_unit
    import control_types_pkg::*;
#(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  mem_op_t     mem_ctrl,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        misaligned_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output lsu_state_t  dbg_state
);

    lsu_state_t  state;
    mem_op_t     op_q;
    logic [1:0]  off_q;
    logic        span_q;
    logic [3:0]  be_hi_q;
    logic [31:0] wd_hi_q;
    // The top byte of the second word can never be selected (off <= 3,
    // size <= 4), so the buffer holds only 7 bytes.
    logic [55:0] rbuf;

    logic        accept;
    logic        reject;
    logic [7:0]  in_be;
    logic [63:0] in_wd;
    logic [55:0] rbuf_next;
    logic [31:0] load_data;

    assign accept    = req_valid && (mem_ctrl != MEM_NOP);
    assign reject    = !ALLOW_MISALIGNED && spans_words(mem_ctrl, addr[1:0]);
    assign in_be     = lane_mask(mem_ctrl, addr[1:0]);
    assign in_wd     = lane_data(mem_ctrl, addr[1:0], wdata);
    assign stall     = !rst && accept && (state != DONE);
    assign dbg_state = state;

    // Read buffer as it will look once the current beat completes, so the
    // final beat's data can feed the aligner in the same cycle.
    always_comb begin
        rbuf_next = rbuf;
        if (state == BEAT0) begin
            rbuf_next[31:0] = mem_rdata;
        end else if (state == BEAT1) begin
            rbuf_next[55:32] = mem_rdata[23:0];
        end
    end

    lsu_load_align u_align (
        .rbuf  (rbuf_next),
        .off   (off_q),
        .op    (op_q),
        .rdata (load_data)
    );

    // Access sequencer: IDLE -> BEAT0 [-> BEAT1] -> DONE -> IDLE, registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            op_q           <= MEM_NOP;
            off_q          <= 2'b00;
            span_q         <= 1'b0;
            be_hi_q        <= 4'b0;
            wd_hi_q        <= 32'b0;
            rbuf           <= 56'b0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= 32'b0;
            mem_be         <= 4'b0;
            mem_wdata      <= 32'b0;
            rdata          <= 32'b0;
            rdata_valid    <= 1'b0;
            misaligned_err <= 1'b0;
        end else begin
            rdata_valid    <= 1'b0;
            misaligned_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q    <= mem_ctrl;
                        off_q   <= addr[1:0];
                        span_q  <= spans_words(mem_ctrl, addr[1:0]);
                        be_hi_q <= in_be[7:4];
                        wd_hi_q <= in_wd[63:32];
                        if (reject) begin
                            state          <= DONE;
                            misaligned_err <= 1'b1;
                        end else begin
                            state     <= BEAT0;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store(mem_ctrl);
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_be    <= in_be[3:0];
                            mem_wdata <= in_wd[31:0];
                        end
                    end
                end
                BEAT0, BEAT1: begin
                    if (mem_ready) begin
                        rbuf <= rbuf_next;
                        if ((state == BEAT0) && span_q) begin
                            state     <= BEAT1;
                            mem_addr  <= mem_addr + 32'd4;
                            mem_be    <= be_hi_q;
                            mem_wdata <= wd_hi_q;
                        end else begin
                            state     <= DONE;
                            mem_req   <= 1'b0;
                            mem_we    <= 1'b0;
                            mem_addr  <= 32'b0;
                            mem_be    <= 4'b0;
                            mem_wdata <= 32'b0;
                            if (is_load(op_q)) begin
                                rdata       <= load_data;
                                rdata_valid <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    rdata <= 32'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
